// File: rtl/synch_mod_counter.sv
// Parametrised synchronous modulo-N up/down counter with load, terminal-count and wrap flags.
// Build option: define COUNT_SATURATE_EN to saturate at the range ends instead of wrapping.
module synch_mod_counter #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16,
    parameter longint RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    output logic [WIDTH-1:0] outBus,
    output logic             tc,
    output logic             wrap
);

    // Illegal parameter combinations stop elaboration.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("synch_mod_counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("synch_mod_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_bad_rst_val
        $error("synch_mod_counter: RST_VAL must be below MODULUS");
    end

    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W  = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   LAST_W = MOD_W - (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] LAST   = LAST_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_W  = RST_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO   = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             atTop, atBottom;

    assign atTop    = (count_q == LAST);
    assign atBottom = (count_q == ZERO);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = ({1'b0, loadVal} < MOD_W) ? loadVal : LAST;
        end else if (en) begin
            if (dir) begin
                if (atTop) begin
`ifdef COUNT_SATURATE_EN
                    count_d = LAST;
`else
                    count_d = ZERO;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (atBottom) begin
`ifdef COUNT_SATURATE_EN
                    count_d = ZERO;
`else
                    count_d = LAST;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_W;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign outBus = count_q;
    assign wrap   = wrap_q;
    assign tc     = en & (dir ? atTop : atBottom);

endmodule

// File: tb/tb_synch_mod_counter.sv
// Scoreboard bench for synch_mod_counter: a MODULUS=10 and a MODULUS=16 instance share stimulus
// and are checked against an independent behavioural model.
module tb_synch_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [3:0] loadVal = '0;
    logic [3:0] out10, out16;
    logic       tc10, tc16, wrap10, wrap16;

    typedef struct {
        int count10;
        bit wrap10;
        int count16;
        bit wrap16;
    } expect_t;

    expect_t expQ[$];
    int      totalCount = 0;
    int      badCount   = 0;
    int      model10    = 0;
    int      model16    = 0;
    bit      modelValid = 1'b0;
    int      wraps16    = 0;

`ifdef COUNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    synch_mod_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) dut10 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .loadVal(loadVal),
        .outBus(out10), .tc(tc10), .wrap(wrap10)
    );

    synch_mod_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) dut16 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .loadVal(loadVal),
        .outBus(out16), .tc(tc16), .wrap(wrap16)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Behavioural reference for one clock edge.
    function automatic void stepModel(input int cur, input int modv, input bit r, input bit l,
                                      input int lv, input bit e, input bit d,
                                      output int nxt, output bit w);
        nxt = cur;
        w   = 1'b0;
        if (r) begin
            nxt = 0;
        end else if (l) begin
            nxt = (lv < modv) ? lv : modv - 1;
        end else if (e) begin
            if (d) begin
                if (cur == modv - 1) begin
                    nxt = SAT ? cur : 0;
                    w   = !SAT;
                end else begin
                    nxt = cur + 1;
                end
            end else begin
                if (cur == 0) begin
                    nxt = SAT ? 0 : modv - 1;
                    w   = !SAT;
                end else begin
                    nxt = cur - 1;
                end
            end
        end
    endfunction

    task automatic applyStimulus(input bit r, input bit l, input int lv, input bit e, input bit d);
        expect_t ex;
        @(negedge clk);
        rst     = r;
        load    = l;
        loadVal = lv[3:0];
        en      = e;
        dir     = d;
        #1;
        if (modelValid) begin
            checkOutput("tc10", {31'd0, tc10}, {31'd0, e && (d ? model10 == 9 : model10 == 0)});
            checkOutput("tc16", {31'd0, tc16}, {31'd0, e && (d ? model16 == 15 : model16 == 0)});
        end
        stepModel(model10, 10, r, l, lv, e, d, ex.count10, ex.wrap10);
        stepModel(model16, 16, r, l, lv, e, d, ex.count16, ex.wrap16);
        model10 = ex.count10;
        model16 = ex.count16;
        if (r) modelValid = 1'b1;
        expQ.push_back(ex);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("queueEmpty", 32'd1, 32'd0);
        end else begin
            ex = expQ.pop_front();
            if (modelValid) begin
                checkOutput("out10", {28'd0, out10}, ex.count10);
                checkOutput("wrap10", {31'd0, wrap10}, {31'd0, ex.wrap10});
                checkOutput("out16", {28'd0, out16}, ex.count16);
                checkOutput("wrap16", {31'd0, wrap16}, {31'd0, ex.wrap16});
            end
        end
        if (wrap16) wraps16++;
    endtask

    initial begin
        // Reset then count up through a wrap
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 1);

        // Count down from reset through the 0 -> top transition
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 0);

        // Load wins over enable, and out-of-range loads clamp
        applyStimulus(0, 1, 7, 1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 12, 1, 0);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 1, 15, 0, 1);

        // Reset wins over load and enable at the top value
        applyStimulus(0, 1, 9, 0, 1);
        applyStimulus(1, 1, 5, 1, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1);

        // Free-running up: two full MODULUS=16 cycles
        applyStimulus(1, 0, 0, 0, 1);
        wraps16 = 0;
        for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("wrapCount16", wraps16, SAT ? 0 : 2);

        // Saturation-style sequence: long up then long down
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 0);

        // Random mix of controls
        for (int i = 0; i < 60; i++) begin
            applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                          int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
